// File: rtl/dm_arbiter.sv
// Two-master data-memory arbiter (CPU = m0, DMA/debug = m1) with DM range check and write trace PC.
// Optional round-robin tie-break between masters: define DM_ARB_ROUND_ROBIN_EN.
module dm_arbiter #(
  parameter logic [31:0] ADDR_LIMIT = 32'h0000_4000,
  parameter logic [31:0] DMA_TAG_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_byteen,
  input  logic [31:0] m0_pc,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_byteen,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_inst_addr,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t      state, state_next;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q;
  logic [3:0]  byteen_q;
  logic        id_q, err_q;
  logic        grant_m1, in_range;

`ifdef DM_ARB_ROUND_ROBIN_EN
  logic last_m1;

  // Tie goes to whoever was not granted last; a sole requester always wins.
  always_comb begin
    if (m0_req && m1_req) grant_m1 = ~last_m1;
    else                  grant_m1 = ~m0_req;
  end

  always_ff @(posedge clk) begin
    if (reset)                          last_m1 <= 1'b1;
    else if (state == IDLE && (m0_req || m1_req)) last_m1 <= grant_m1;
  end
`else
  assign grant_m1 = ~m0_req;
`endif

  assign in_range = (addr_q < ADDR_LIMIT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      byteen_q <= '0;
      pc_q     <= '0;
      id_q     <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && (m0_req || m1_req)) begin
        id_q     <= grant_m1;
        addr_q   <= grant_m1 ? m1_addr   : m0_addr;
        wdata_q  <= grant_m1 ? m1_wdata  : m0_wdata;
        byteen_q <= grant_m1 ? m1_byteen : m0_byteen;
        pc_q     <= grant_m1 ? DMA_TAG_PC : m0_pc;
      end
      if (state == ACCESS) begin
        rdata_q <= in_range ? mem_rdata : '0;
        err_q   <= ~in_range;
      end
    end
  end

  // Outputs are gated by reset so an ACCESS cycle coincident with reset never writes.
  always_comb begin
    state_next    = state;
    m0_ack        = 1'b0;
    m0_rdata      = '0;
    m0_err        = 1'b0;
    m1_ack        = 1'b0;
    m1_rdata      = '0;
    m1_err        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_byteen    = '0;
    mem_inst_addr = '0;
    busy          = 1'b0;
    case (state)
      IDLE:    if (m0_req || m1_req) state_next = ACCESS;
      ACCESS:  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (!reset) begin
      busy = (state != IDLE);
      if (state == ACCESS) begin
        mem_addr      = addr_q & 32'hFFFF_FFFC;
        mem_wdata     = wdata_q;
        mem_byteen    = in_range ? byteen_q : 4'b0000;
        mem_inst_addr = pc_q;
      end
      if (state == DONE) begin
        if (id_q) begin
          m1_ack   = 1'b1;
          m1_rdata = rdata_q;
          m1_err   = err_q;
        end else begin
          m0_ack   = 1'b1;
          m0_rdata = rdata_q;
          m0_err   = err_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a byte-merging data-memory model.
`timescale 1ns/1ps
module tb_dm_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m0_wdata, m0_pc, m1_addr, m1_wdata;
  logic [3:0]  m0_byteen, m1_byteen;
  logic        m0_ack, m0_err, m1_ack, m1_err, busy;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, mem_inst_addr;
  logic [3:0]  mem_byteen;

  logic [31:0] mem [0:4095];
  int          wr_count;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  dm_arbiter #(.ADDR_LIMIT(32'h0000_4000), .DMA_TAG_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_byteen(m0_byteen), .m0_pc(m0_pc),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_byteen(m1_byteen),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_byteen(mem_byteen),
    .mem_rdata(mem_rdata), .mem_inst_addr(mem_inst_addr), .busy(busy)
  );

  assign mem_rdata = mem[mem_addr[13:2]];

  always @(posedge clk) begin
    if (mem_byteen != 4'b0000) begin
      for (int unsigned b = 0; b < 4; b++)
        if (mem_byteen[b]) mem[mem_addr[13:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
      wr_count <= wr_count + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_addr = '0; m0_wdata = '0; m0_byteen = '0; m0_pc = '0;
    m1_req = 0; m1_addr = '0; m1_wdata = '0; m1_byteen = '0;
  endtask

  // One complete access from IDLE back to IDLE, checking ACCESS, DONE and the return to IDLE.
  task automatic run_access(input logic m, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] be, input logic [31:0] pc,
                            input logic [31:0] exp_rd, input logic exp_err);
    @(posedge clk); #1;
    if (m) begin m1_req = 1; m1_addr = a; m1_wdata = wd; m1_byteen = be; end
    else   begin m0_req = 1; m0_addr = a; m0_wdata = wd; m0_byteen = be; m0_pc = pc; end
    @(posedge clk); @(negedge clk);
    chk("acc_busy", {31'b0, busy}, 32'd1);
    chk("acc_addr", mem_addr, a & 32'hFFFF_FFFC);
    chk("acc_wdata", mem_wdata, wd);
    chk("acc_byteen", {28'b0, mem_byteen}, (a < 32'h4000) ? {28'b0, be} : 32'd0);
    chk("acc_inst", mem_inst_addr, m ? 32'h0 : pc);
    chk("acc_noack", {30'b0, m1_ack, m0_ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("done_ack", {30'b0, m1_ack, m0_ack}, m ? 32'd2 : 32'd1);
    chk("done_rdata", m ? m1_rdata : m0_rdata, exp_rd);
    chk("done_err", {31'b0, m ? m1_err : m0_err}, {31'b0, exp_err});
    chk("done_loser", m ? m0_rdata : m1_rdata, 32'd0);
    chk("done_byteen", {28'b0, mem_byteen}, 32'd0);
    m0_req = 0; m1_req = 0;
    @(posedge clk); @(negedge clk);
    chk("idle_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[0] = 32'h1234_5678;
    mem[8] = 32'hAAAA_0008;
    mem[9] = 32'hBBBB_0009;
    wr_count = 0;
    idle_inputs();
    reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_acks", {30'b0, m1_ack, m0_ack}, 32'd0);
    chk("rst_byteen", {28'b0, mem_byteen}, 32'd0);
    reset = 0;
    @(negedge clk);
    chk("rst_idle_busy", {31'b0, busy}, 32'd0);

    run_access(1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_3004, 32'h0, 1'b0);
    chk("mem4", mem[4], 32'hDEAD_BEEF);
    chk("wr1", wr_count, 1);
    run_access(1'b0, 32'h0000_0013, 32'h0, 4'h0, 32'h0000_3008, 32'hDEAD_BEEF, 1'b0);
    chk("wr_after_read", wr_count, 1);
    run_access(1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'hF, 32'h0, 32'h0, 1'b1);
    run_access(1'b1, 32'h0000_4000, 32'h0, 4'h0, 32'h0, 32'h0, 1'b1);
    chk("wr_oor", wr_count, 1);
    chk("mem0_kept", mem[0], 32'h1234_5678);
    run_access(1'b0, 32'h0000_0008, 32'h1111_CAFE, 4'b0011, 32'h0000_3010, 32'h0, 1'b0);
    run_access(1'b1, 32'h0000_0008, 32'h0, 4'h0, 32'h0, 32'h0000_CAFE, 1'b0);

    // Both requesting continuously; last grant was m1.
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 32'h20; m0_byteen = 0; m0_pc = 32'h3100;
    m1_req = 1; m1_addr = 32'h24; m1_byteen = 0;
    for (int s = 0; s < 4; s++) begin
      logic exp_m1;
`ifdef DM_ARB_ROUND_ROBIN_EN
      exp_m1 = (s % 2) == 1;
`else
      exp_m1 = 1'b0;
`endif
      @(posedge clk); @(negedge clk);
      chk("tie_addr", mem_addr, exp_m1 ? 32'h24 : 32'h20);
      @(posedge clk); @(negedge clk);
      chk("tie_ack", {30'b0, m1_ack, m0_ack}, exp_m1 ? 32'd2 : 32'd1);
      chk("tie_rdata", exp_m1 ? m1_rdata : m0_rdata, exp_m1 ? 32'hBBBB_0009 : 32'hAAAA_0008);
      if (s == 3) begin m0_req = 0; m1_req = 0; end
      @(posedge clk);
    end
    @(negedge clk);
    chk("tie_end_busy", {31'b0, busy}, 32'd0);

    // Reset during ACCESS of an m1 write.
    @(posedge clk); #1;
    m1_req = 1; m1_addr = 32'h30; m1_wdata = 32'h5555_5555; m1_byteen = 4'hF;
    @(posedge clk); @(negedge clk);
    reset = 1;
    #1;
    chk("rstacc_byteen", {28'b0, mem_byteen}, 32'd0);
    chk("rstacc_busy", {31'b0, busy}, 32'd0);
    @(posedge clk); #1;
    reset = 0; m1_req = 0;
    @(negedge clk);
    chk("rstacc_idle", {29'b0, busy, m1_ack, m0_ack}, 32'd0);
    chk("rstacc_mem12", mem[12], 32'h0);
    chk("rstacc_wr", wr_count, 2);

    // m0 drops req and changes addr mid-ACCESS: latched addr is used.
    @(posedge clk); #1;
    m0_req = 1; m0_addr = 32'h10; m0_byteen = 0; m0_pc = 32'h3200;
    @(posedge clk); @(negedge clk);
    m0_req = 0; m0_addr = 32'h44;
    #1;
    chk("drop_addr", mem_addr, 32'h10);
    @(posedge clk); @(negedge clk);
    chk("drop_ack", {30'b0, m1_ack, m0_ack}, 32'd1);
    chk("drop_rdata", m0_rdata, 32'hDEAD_BEEF);
    @(posedge clk); @(negedge clk);
    chk("drop_idle", {29'b0, busy, m1_ack, m0_ack}, 32'd0);
    @(posedge clk); @(negedge clk);
    chk("drop_noreack", {29'b0, busy, m1_ack, m0_ack}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
